// File: rtl/barrel_shifter_pipe.sv
// Two-stage pipelined barrel shifter: SRL, SRA, SLL, ROL, ROR with carry/zero/illegal flags.
// Stage A applies the low half of the log shift levels, stage B the rest plus flag generation.
module barrel_shifter_pipe #(
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_d,
   input  logic [$clog2(WIDTH)-1:0]   in_s,
   input  logic [2:0]                 in_op,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_q,
   output logic                       out_carry,
   output logic                       out_zero,
   output logic                       out_illegal
);

   localparam int SW = $clog2(WIDTH);
   localparam int LA = SW / 2;
   localparam logic [SW-1:0] ONE_S  = SW'(1);
   localparam logic [SW-1:0] ZERO_S = '0;

   localparam logic [2:0] OP_SRL = 3'b000;
   localparam logic [2:0] OP_SRA = 3'b001;
   localparam logic [2:0] OP_SLL = 3'b010;
   localparam logic [2:0] OP_ROL = 3'b011;
   localparam logic [2:0] OP_ROR = 3'b100;

   // One shifter level by a fixed amount; illegal ops pass the value through untouched.
   function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] v,
                                                    input logic [2:0] op,
                                                    input int amt);
      logic [WIDTH-1:0] r;
      case (op)
         OP_SRL:  r = v >> amt;
         OP_SRA:  r = $unsigned($signed(v) >>> amt);
         OP_SLL:  r = v << amt;
         OP_ROL:  r = (v << amt) | (v >> (WIDTH - amt));
         OP_ROR:  r = (v >> amt) | (v << (WIDTH - amt));
         default: r = v;
      endcase
      return r;
   endfunction

   logic             a_valid;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] a_d;
   logic [SW-1:0]    a_s;
   logic [2:0]       a_op;

   logic             b_valid;
   logic [WIDTH-1:0] b_q;
   logic             b_carry;
   logic             b_zero;
   logic             b_illegal;

   logic             b_free;
   logic             a_load;
   logic             b_load;
   logic [WIDTH-1:0] a_next;
   logic [WIDTH-1:0] b_next;
   logic [SW-1:0]    s_m1;
   logic [SW-1:0]    s_neg;
   logic             carry_next;
   logic             illegal_next;

   // Valid/ready: a transfer happens on any edge where valid and ready are both high;
   // a stage loads when it is empty or its current contents leave on the same edge.
   assign b_free   = !b_valid || out_ready;
   assign in_ready = !a_valid || b_free;
   assign a_load   = in_valid && in_ready;
   assign b_load   = a_valid && b_free;

   always_comb begin
      a_next = in_d;
      for (int k = 0; k < LA; k++) begin
         if (in_s[k]) a_next = shift_level(a_next, in_op, 1 << k);
      end
   end

   always_comb begin
      b_next = a_q;
      for (int k = LA; k < SW; k++) begin
         if (a_s[k]) b_next = shift_level(b_next, a_op, 1 << k);
      end
   end

   // Carry indices wrap modulo WIDTH, so WIDTH-s reduces to a plain negation of s.
   always_comb begin
      s_m1         = a_s - ONE_S;
      s_neg        = ZERO_S - a_s;
      illegal_next = (a_op > OP_ROR);
      carry_next   = 1'b0;
      case (a_op)
         OP_SRL, OP_SRA: carry_next = a_d[s_m1];
         OP_SLL:         carry_next = a_d[s_neg];
         OP_ROL:         carry_next = b_next[0];
         OP_ROR:         carry_next = b_next[WIDTH-1];
         default:        carry_next = 1'b0;
      endcase
      if (a_s == ZERO_S) carry_next = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_valid <= 1'b0;
         a_q     <= '0;
         a_d     <= '0;
         a_s     <= '0;
         a_op    <= '0;
      end else begin
         if (a_load) begin
            a_valid <= 1'b1;
            a_q     <= a_next;
            a_d     <= in_d;
            a_s     <= in_s;
            a_op    <= in_op;
         end else if (b_load) begin
            a_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_valid   <= 1'b0;
         b_q       <= '0;
         b_carry   <= 1'b0;
         b_zero    <= 1'b0;
         b_illegal <= 1'b0;
      end else begin
         if (b_load) begin
            b_valid   <= 1'b1;
            b_q       <= b_next;
            b_carry   <= carry_next;
            b_zero    <= (b_next == '0);
            b_illegal <= illegal_next;
         end else if (out_ready) begin
            b_valid <= 1'b0;
         end
      end
   end

   // Outputs read zero whenever no result is presented, so a drained stage B never leaks stale data.
   assign out_valid   = b_valid;
   assign out_q       = b_valid ? b_q : '0;
   assign out_carry   = b_valid && b_carry;
   assign out_zero    = b_valid && b_zero;
   assign out_illegal = b_valid && b_illegal;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe at WIDTH 8, 32 and 64 with a bit-level reference model.
// One shared stimulus bus feeds the instance picked by sel; outputs are muxed back the same way.
module tb_barrel_shifter_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  sel;
   logic        drv_valid;
   logic [63:0] drv_d;
   logic [5:0]  drv_s;
   logic [2:0]  drv_op;
   logic        man_ready;
   logic        bp_rand = 1'b1;
   logic        bp_en;
   logic        out_ready;

   always #5 clk = ~clk;

   logic        r8, v8, c8, z8, i8;
   logic [7:0]  q8;
   logic        r32, v32, c32, z32, i32;
   logic [31:0] q32;
   logic        r64, v64, c64, z64, i64;
   logic [63:0] q64;

   logic        m_ready, m_valid, m_carry, m_zero, m_illegal;
   logic [63:0] m_q;

   assign out_ready = bp_en ? bp_rand : man_ready;

   barrel_shifter_pipe #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(drv_valid && sel == 2'd0), .in_ready(r8),
      .in_d(drv_d[7:0]), .in_s(drv_s[2:0]), .in_op(drv_op), .out_valid(v8), .out_ready(out_ready),
      .out_q(q8), .out_carry(c8), .out_zero(z8), .out_illegal(i8));

   barrel_shifter_pipe #(.WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(drv_valid && sel == 2'd1), .in_ready(r32),
      .in_d(drv_d[31:0]), .in_s(drv_s[4:0]), .in_op(drv_op), .out_valid(v32), .out_ready(out_ready),
      .out_q(q32), .out_carry(c32), .out_zero(z32), .out_illegal(i32));

   barrel_shifter_pipe #(.WIDTH(64)) dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(drv_valid && sel == 2'd2), .in_ready(r64),
      .in_d(drv_d), .in_s(drv_s), .in_op(drv_op), .out_valid(v64), .out_ready(out_ready),
      .out_q(q64), .out_carry(c64), .out_zero(z64), .out_illegal(i64));

   always_comb begin
      m_ready = r8; m_valid = v8; m_q = {56'b0, q8}; m_carry = c8; m_zero = z8; m_illegal = i8;
      if (sel == 2'd1) begin
         m_ready = r32; m_valid = v32; m_q = {32'b0, q32}; m_carry = c32; m_zero = z32; m_illegal = i32;
      end else if (sel == 2'd2) begin
         m_ready = r64; m_valid = v64; m_q = q64; m_carry = c64; m_zero = z64; m_illegal = i64;
      end
   end

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   bit          lat_chk = 1'b0;
   logic [66:0] exp_q[$];
   int          lat_q[$];
   logic [66:0] mon_e;
   int          mon_t;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      bp_rand = ($urandom_range(0, 3) != 0);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [66:0] pk(input logic [63:0] q, input bit c, input bit z, input bit il);
      return {q, c, z, il};
   endfunction

   function automatic logic [63:0] mask(input int w);
      logic [63:0] m;
      m = '1;
      if (w < 64) m = (64'd1 << w) - 64'd1;
      return m;
   endfunction

   // Reference: each result bit is picked straight from the operand by index arithmetic.
   function automatic logic [66:0] model(input logic [63:0] d, input int s, input logic [2:0] op, input int w);
      logic [63:0] q;
      bit          c;
      q = '0;
      c = 1'b0;
      if (op > 3'd4) return pk(d, 1'b0, d == 64'd0, 1'b1);
      for (int i = 0; i < w; i++) begin
         case (op)
            3'd0:    q[i] = (i + s < w) ? d[i + s] : 1'b0;
            3'd1:    q[i] = (i + s < w) ? d[i + s] : d[w - 1];
            3'd2:    q[i] = (i >= s) ? d[i - s] : 1'b0;
            3'd3:    q[i] = d[(i - s + w) % w];
            default: q[i] = d[(i + s) % w];
         endcase
      end
      if (s != 0) begin
         case (op)
            3'd0, 3'd1: c = d[s - 1];
            3'd2:       c = d[w - s];
            3'd3:       c = q[0];
            default:    c = q[w - 1];
         endcase
      end
      return pk(q, c, q == 64'd0, 1'b0);
   endfunction

   // Monitor: pops and compares on every output transfer, and checks idle outputs read zero.
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_output: got q=%h with no operation outstanding", m_q);
            end else begin
               mon_e = exp_q.pop_front();
               mon_t = lat_q.pop_front();
               chk("out_q", m_q, mon_e[66:3]);
               chk("out_carry", 64'(m_carry), 64'(mon_e[2]));
               chk("out_zero", 64'(m_zero), 64'(mon_e[1]));
               chk("out_illegal", 64'(m_illegal), 64'(mon_e[0]));
               if (lat_chk) chk("latency", 64'(cyc - mon_t), 64'd2);
            end
         end else if (!m_valid) begin
            chk("idle_outputs_zero", m_q | 64'({m_carry, m_zero, m_illegal}), 64'd0);
         end
      end
   end

   task automatic try_send(input logic [63:0] d, input logic [5:0] s, input logic [2:0] op,
                           input logic [66:0] e, output bit acc);
      @(negedge clk);
      drv_valid = 1'b1;
      drv_d     = d;
      drv_s     = s;
      drv_op    = op;
      #1;
      acc = m_ready;
      if (acc) begin
         exp_q.push_back(e);
         lat_q.push_back(cyc);
      end
      @(posedge clk);
      #1;
      drv_valid = 1'b0;
   endtask

   task automatic send(input logic [63:0] d, input logic [5:0] s, input logic [2:0] op,
                       input logic [66:0] e);
      bit acc;
      int n;
      n = 0;
      do begin
         try_send(d, s, op, e, acc);
         n++;
      end while (!acc && n < 200);
      if (!acc) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
      end
   endtask

   task automatic send_rand(input int w);
      logic [63:0] d;
      int          s;
      logic [2:0]  op;
      d  = {$urandom(), $urandom()} & mask(w);
      s  = $urandom_range(0, w - 1);
      op = 3'($urandom_range(0, 7));
      send(d, 6'(s), op, model(d, s, op, w));
   endtask

   task automatic drain();
      int n;
      @(posedge clk);
      #1;
      bp_en     = 1'b0;
      man_ready = 1'b1;
      n = 0;
      while (exp_q.size() > 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      chk("drain_outstanding", 64'(exp_q.size()), 64'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not finish, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      bit          acc;
      int          nacc;
      logic [66:0] hold;
      int          widths[3];
      widths = '{8, 32, 64};
      sel = 2'd0; drv_valid = 1'b0; drv_d = '0; drv_s = '0; drv_op = '0;
      man_ready = 1'b1; bp_en = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", 64'(m_valid), 64'd0);
      chk("reset_out_q", m_q, 64'd0);
      chk("reset_flags", 64'({m_carry, m_zero, m_illegal}), 64'd0);
      chk("reset_in_ready", 64'(m_ready), 64'd1);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready_after_reset", 64'(m_ready), 64'd1);

      // Directed WIDTH=8 cases with hand-computed results and latency checks.
      lat_chk = 1'b1;
      send(64'hB4, 6'd3, 3'b001, pk(64'hF6, 1'b1, 1'b0, 1'b0)); drain();
      send(64'h81, 6'd1, 3'b011, pk(64'h03, 1'b1, 1'b0, 1'b0)); drain();
      send(64'h81, 6'd1, 3'b100, pk(64'hC0, 1'b1, 1'b0, 1'b0)); drain();
      send(64'h80, 6'd1, 3'b010, pk(64'h00, 1'b1, 1'b1, 1'b0)); drain();
      send(64'h80, 6'd0, 3'b000, pk(64'h80, 1'b0, 1'b0, 1'b0)); drain();
      send(64'h5A, 6'd2, 3'b110, pk(64'h5A, 1'b0, 1'b0, 1'b1)); drain();
      lat_chk = 1'b0;

      // Backpressure: four back-to-back offers with the consumer stalled.
      man_ready = 1'b0;
      nacc = 0;
      for (int i = 0; i < 4; i++) begin
         logic [63:0] d;
         d = 64'($urandom_range(0, 255));
         try_send(d, 6'(i + 1), 3'(i), model(d, i + 1, 3'(i), 8), acc);
         nacc += int'(acc);
      end
      chk("bp_accepted", 64'(nacc), 64'd2);
      @(negedge clk);
      chk("bp_in_ready", 64'(m_ready), 64'd0);
      hold = exp_q[0];
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", 64'(m_valid), 64'd1);
         chk("bp_hold_q", m_q, hold[66:3]);
         chk("bp_hold_carry", 64'(m_carry), 64'(hold[2]));
      end
      drain();

      // Reset with two operations in flight: nothing may survive it.
      man_ready = 1'b0;
      send(64'h3C, 6'd2, 3'b010, pk(64'hF0, 1'b0, 1'b0, 1'b0));
      send(64'hFF, 6'd4, 3'b000, pk(64'h0F, 1'b1, 1'b0, 1'b0));
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midreset_out_valid", 64'(m_valid), 64'd0);
      chk("midreset_out_q", m_q, 64'd0);
      exp_q.delete();
      lat_q.delete();
      @(posedge clk);
      #1 man_ready = 1'b1;
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready_after_midreset", 64'(m_ready), 64'd1);
      chk("no_stale_valid", 64'(m_valid), 64'd0);
      repeat (6) @(posedge clk);
      #1;

      // Randomized traffic with random backpressure at each width.
      for (int wi = 0; wi < 3; wi++) begin
         sel   = 2'(wi);
         bp_en = 1'b1;
         repeat (150) send_rand(widths[wi]);
         drain();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
